// File: rtl/vga_timing_gen.sv
// Raster timing generator: divided pixel tick, h/v position counters, sync/DE
// with a programmable pixel-period delay, and line/frame/line-match strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_DLY = 0,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          resync,
    input  logic [CW-1:0] line_match,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          line_irq
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic H_ACT  = (H_POL != 0);
    localparam logic V_ACT  = (V_POL != 0);

    if ((H_TOTAL - 1) >= (1 << CW)) begin : g_bad_htotal
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if ((V_TOTAL - 1) >= (1 << CW)) begin : g_bad_vtotal
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 15) begin : g_bad_dly
        $error("vga_timing_gen: SYNC_DLY must be within 0..15");
    end

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [2:0]    raw;      // {de, hs, vs}, active-high
    logic [2:0]    dly;

    always_comb begin
        p_tick = en && (div_q == '0);
        raw[2] = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
        raw[1] = (h_q >= CW'(HS_FIRST)) && (h_q <= CW'(HS_LAST));
        raw[0] = (v_q >= CW'(VS_FIRST)) && (v_q <= CW'(VS_LAST));
    end

    // resync outranks the tick and is honoured even while en is low.
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (resync) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (en) begin
            div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
            if (p_tick) begin
                if (h_q == CW'(H_TOTAL - 1)) begin
                    h_d = '0;
                    v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
                end else begin
                    h_d = h_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // With no delay the sync/DE outputs follow the current position directly.
    if (SYNC_DLY == 0) begin : g_nodly
        assign dly = raw;
    end else begin : g_dly
        logic [SYNC_DLY-1:0][2:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d = pipe_q;
            if (resync) begin
                pipe_d = '0;
            end else if (p_tick) begin
                pipe_d[0] = raw;
                for (int i = 1; i < SYNC_DLY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign dly = pipe_q[SYNC_DLY-1];
    end

    assign x           = h_q;
    assign y           = v_q;
    assign de          = dly[2];
    assign hsync       = (dly[1] == H_ACT);
    assign vsync       = (dly[0] == V_ACT);
    assign line_start  = p_tick && (h_q == '0);
    assign frame_start = line_start && (v_q == '0);
    assign line_irq    = line_start && (v_q == line_match);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a
// pixel-count model, plus directed scenarios with hand-computed expectations.
module tb_vga_timing_gen;

    localparam int CW = 11;

    typedef struct packed {
        logic          p;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic          de;
        logic          ls;
        logic          fs;
        logic          irq;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // default-format instance
    logic en_def = 1'b1, rs_def = 1'b0;
    logic [CW-1:0] lm_def = '0;
    logic p_def, hs_def, vs_def, de_def, ls_def, fs_def, irq_def;
    logic [CW-1:0] x_def, y_def;
    // small raster, CLK_DIV=1, SYNC_DLY=2, H_POL=1
    logic en_sm = 1'b1, rs_sm = 1'b0;
    logic [CW-1:0] lm_sm = 11'd2;
    logic p_sm, hs_sm, vs_sm, de_sm, ls_sm, fs_sm, irq_sm;
    logic [CW-1:0] x_sm, y_sm;
    // small raster, CLK_DIV=3, SYNC_DLY=1
    logic en_div = 1'b1, rs_div = 1'b0;
    logic [CW-1:0] lm_div = '0;
    logic p_div, hs_div, vs_div, de_div, ls_div, fs_div, irq_div;
    logic [CW-1:0] x_div, y_div;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .en(en_def), .resync(rs_def), .line_match(lm_def),
        .p_tick(p_def), .x(x_def), .y(y_def), .hsync(hs_def), .vsync(vs_def),
        .de(de_def), .line_start(ls_def), .frame_start(fs_def), .line_irq(irq_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(0), .CLK_DIV(1), .SYNC_DLY(2), .CW(CW)
    ) u_sm (
        .clk(clk), .rst(rst), .en(en_sm), .resync(rs_sm), .line_match(lm_sm),
        .p_tick(p_sm), .x(x_sm), .y(y_sm), .hsync(hs_sm), .vsync(vs_sm),
        .de(de_sm), .line_start(ls_sm), .frame_start(fs_sm), .line_irq(irq_sm)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(3), .SYNC_DLY(1), .CW(CW)
    ) u_div (
        .clk(clk), .rst(rst), .en(en_div), .resync(rs_div), .line_match(lm_div),
        .p_tick(p_div), .x(x_div), .y(y_div), .hsync(hs_div), .vsync(vs_div),
        .de(de_div), .line_start(ls_div), .frame_start(fs_div), .line_irq(irq_div)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model state is the number of pixel ticks since the frame origin plus
    // the clk phase within the current pixel; every output derives from it.
    function automatic out_t model_out(input int t, input int ph, input logic e,
                                       input int lm, input int ha, input int hfp,
                                       input int hsw, input int hbp, input int va,
                                       input int vfp, input int vsw, input int vbp,
                                       input int hpol, input int vpol, input int d);
        out_t o;
        int ht, vt, px, py, td, xd, yd;
        logic hsa, vsa, dea;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        px  = t % ht;
        py  = (t / ht) % vt;
        hsa = 1'b0;
        vsa = 1'b0;
        dea = 1'b0;
        if (t >= d) begin
            td  = t - d;
            xd  = td % ht;
            yd  = (td / ht) % vt;
            dea = (xd < ha) && (yd < va);
            hsa = (xd >= ha + hfp) && (xd < ha + hfp + hsw);
            vsa = (yd >= va + vfp) && (yd < va + vfp + vsw);
        end
        o.p   = e && (ph == 0);
        o.x   = CW'(px);
        o.y   = CW'(py);
        o.hs  = (hpol != 0) ? hsa : !hsa;
        o.vs  = (vpol != 0) ? vsa : !vsa;
        o.de  = dea;
        o.ls  = o.p && (px == 0);
        o.fs  = o.ls && (py == 0);
        o.irq = o.ls && (py == lm);
        return o;
    endfunction

    task automatic advance(inout int t, inout int ph, input logic e, input logic rs,
                           input int div);
        if (rs) begin
            t  = 0;
            ph = 0;
        end else if (e) begin
            if (ph == 0) t++;
            ph = (ph + 1) % div;
        end
    endtask

    int t_def = 0, ph_def = 0, t_sm = 0, ph_sm = 0, t_div = 0, ph_div = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_def = 0; ph_def = 0;
            t_sm  = 0; ph_sm  = 0;
            t_div = 0; ph_div = 0;
        end else begin
            advance(t_def, ph_def, en_def, rs_def, 4);
            advance(t_sm, ph_sm, en_sm, rs_sm, 1);
            advance(t_div, ph_div, en_div, rs_div, 3);
        end
    end

    always @(negedge clk) begin
        check_vec("def_cycle",
                  {p_def, x_def, y_def, hs_def, vs_def, de_def, ls_def, fs_def, irq_def},
                  model_out(t_def, ph_def, en_def, int'(lm_def),
                            640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0));
        check_vec("sm_cycle",
                  {p_sm, x_sm, y_sm, hs_sm, vs_sm, de_sm, ls_sm, fs_sm, irq_sm},
                  model_out(t_sm, ph_sm, en_sm, int'(lm_sm),
                            4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 2));
        check_vec("div_cycle",
                  {p_div, x_div, y_div, hs_div, vs_div, de_div, ls_div, fs_div, irq_div},
                  model_out(t_div, ph_div, en_div, int'(lm_div),
                            4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 1));
    end

    task automatic run_sm();
        int fs_k[$];
        int de_x = -1, de_y = -1, hs_hi = 0, hs_bad = 0, x_bad = 0;
        int irq_n = 0, irq_x = -1, irq_y = -1, irq_ls = 0, ls_n = 0;
        logic found;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (fs_sm) fs_k.push_back(k);
            if (de_sm && de_x < 0) begin
                de_x = int'(x_sm);
                de_y = int'(y_sm);
            end
            if (int'(x_sm) != (k + 1) % 8) x_bad++;
            if (k >= 47 && k < 95) begin
                if (hs_sm) begin
                    hs_hi++;
                    if (x_sm != 7 && x_sm != 0) hs_bad++;
                end
                if (irq_sm) begin
                    irq_n++;
                    irq_x  = int'(x_sm);
                    irq_y  = int'(y_sm);
                    irq_ls = int'(ls_sm);
                end
            end
        end
        check("sm_fs_count", fs_k.size(), 2);
        if (fs_k.size() >= 2) begin
            check("sm_first_fs", fs_k[0], 47);
            check("sm_frame_period", fs_k[1] - fs_k[0], 48);
        end
        check("sm_x_sequence", x_bad, 0);
        check("sm_de_first_x", de_x, 2);
        check("sm_de_first_y", de_y, 0);
        check("sm_hsync_high_count", hs_hi, 12);
        check("sm_hsync_outside_7_0", hs_bad, 0);
        check("sm_irq_count", irq_n, 1);
        check("sm_irq_x", irq_x, 0);
        check("sm_irq_y", irq_y, 2);
        check("sm_irq_with_line_start", irq_ls, 1);

        #1 lm_sm = 11'd6;
        irq_n = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (irq_sm) irq_n++;
            if (ls_sm) ls_n++;
        end
        check("sm_irq_out_of_range", irq_n, 0);
        check("sm_line_starts_per_frame", ls_n, 6);

        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (x_sm == 5 && y_sm == 1) begin
                found = 1'b1;
                break;
            end
        end
        check("sm_reach_x5_y1", int'(found), 1);
        #1 rs_sm = 1'b1;
        @(negedge clk);
        check("sm_resync_x", int'(x_sm), 0);
        check("sm_resync_y", int'(y_sm), 0);
        check("sm_resync_de", int'(de_sm), 0);
        check("sm_resync_hsync", int'(hs_sm), 0);
        check("sm_resync_vsync", int'(vs_sm), 1);
        check("sm_resync_frame_start", int'(fs_sm), 1);
        #1 rs_sm = 1'b0;
    endtask

    task automatic run_div();
        int exp_p[5];
        int exp_x[5];
        int frz_bad = 0;
        logic found = 1'b0;
        exp_p = '{0, 1, 0, 0, 1};
        exp_x = '{3, 3, 4, 4, 4};
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (p_div && x_div == 2 && y_div == 0) begin
                found = 1'b1;
                break;
            end
        end
        check("div_reach_x2", int'(found), 1);
        @(negedge clk);
        check("div_mid_pixel_x", int'(x_div), 3);
        check("div_mid_pixel_tick", int'(p_div), 0);
        #1 en_div = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (x_div != 3 || y_div != 0 || p_div || ls_div || fs_div || irq_div) frz_bad++;
        end
        check("div_frozen", frz_bad, 0);
        #1 en_div = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("div_resume_tick_%0d", k), int'(p_div), exp_p[k]);
            check($sformatf("div_resume_x_%0d", k), int'(x_div), exp_x[k]);
        end
    endtask

    task automatic run_def();
        int n_hs = 0, n_hs_clk = 0, n_de = 0, n_vs = 0, n_ls = 0;
        int first_x = -1, last_x = -1;
        logic found = 1'b0;
        for (int k = 0; k < 3300; k++) begin
            @(negedge clk);
            if (ls_def) begin
                found = 1'b1;
                break;
            end
        end
        check("def_reach_line_start", int'(found), 1);
        for (int k = 0; k < 3200; k++) begin
            if (k > 0) @(negedge clk);
            if (!hs_def) n_hs_clk++;
            if (p_def && !hs_def) begin
                n_hs++;
                if (first_x < 0) first_x = int'(x_def);
                last_x = int'(x_def);
            end
            if (p_def && de_def) n_de++;
            if (!vs_def) n_vs++;
            if (ls_def) n_ls++;
        end
        check("def_hsync_ticks", n_hs, 96);
        check("def_hsync_clks", n_hs_clk, 384);
        check("def_hsync_first_x", first_x, 656);
        check("def_hsync_last_x", last_x, 751);
        check("def_de_ticks", n_de, 640);
        check("def_vsync_low", n_vs, 0);
        check("def_line_starts", n_ls, 1);
    endtask

    initial begin
        logic found;
        #1 rst = 1'b1;
        #2;
        check("rst_sm_x", int'(x_sm), 0);
        check("rst_sm_y", int'(y_sm), 0);
        check("rst_sm_hsync", int'(hs_sm), 0);
        check("rst_sm_vsync", int'(vs_sm), 1);
        check("rst_sm_de", int'(de_sm), 0);
        check("rst_div_hsync", int'(hs_div), 1);
        check("rst_div_de", int'(de_div), 0);
        check("rst_def_hsync", int'(hs_def), 1);
        check("rst_def_vsync", int'(vs_def), 1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("first_sm_p_tick", int'(p_sm), 1);
        check("first_sm_line_start", int'(ls_sm), 1);
        check("first_sm_frame_start", int'(fs_sm), 1);
        check("first_sm_line_irq", int'(irq_sm), 0);
        check("first_div_line_irq", int'(irq_div), 1);
        check("first_def_frame_start", int'(fs_def), 1);

        fork
            run_sm();
            run_div();
            run_def();
        join

        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hs_sm) begin
                found = 1'b1;
                break;
            end
        end
        check("sm_reach_hsync", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_x", int'(x_sm), 0);
        check("async_rst_y", int'(y_sm), 0);
        check("async_rst_hsync", int'(hs_sm), 0);
        check("async_rst_vsync", int'(vs_sm), 1);
        check("async_rst_de", int'(de_sm), 0);
        check("async_rst_def_x", int'(x_def), 0);
        check("async_rst_def_hsync", int'(hs_def), 1);
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator. It produces hsync, vsync, display-enable, pixel coordinates and frame/line strobes for any raster format, using a programmable pixel-clock divider. It sits between the system clock and the pixel generators. It replaces the fixed 640x480 sync block and adds:
- configurable sync polarity;
- a sync/DE delay pipeline that aligns with downstream pixel latency;
- run/hold and resync control;
- a line-match interrupt.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- H_POL, 0: hsync active level (0 = active-low, 1 = active-high)
- V_POL, 0: vsync active level
- CLK_DIV, 4: clk cycles per pixel, ≥1
- SYNC_DLY, 0: pixel-period delay of hsync/vsync/de relative to x/y, 0..15
- CW, 11: coordinate/counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; low freezes all timing state
- resync  in  1  synchronous restart of frame at (0,0)
- line_match  in  CW  line number for line_irq
- p_tick  out  1  pixel-enable strobe, one clk wide
- x  out  CW  current horizontal count
- y  out  CW  current vertical count
- hsync  out  1  horizontal sync, polarity H_POL, delayed SYNC_DLY
- vsync  out  1  vertical sync, polarity V_POL, delayed SYNC_DLY
- de  out  1  display enable, delayed SYNC_DLY
- line_start  out  1  one-clk pulse at start of each line
- frame_start  out  1  one-clk pulse at start of each frame
- line_irq  out  1  one-clk pulse at start of line line_match

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration fails if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, if CLK_DIV<1, or if SYNC_DLY>15.
- Line order: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch. Vertical uses the same order.
- Divider: div counts 0..CLK_DIV-1 and wraps. p_tick = en && div==0. With CLK_DIV=1, p_tick = en.
- On a clk edge with p_tick high:
  - h increments, wrapping H_TOTAL-1 → 0.
  - When h wraps, v increments, wrapping V_TOTAL-1 → 0.
- en low: div, h, v and the delay pipeline hold. p_tick, line_start, frame_start and line_irq are 0.
- resync high on a clk edge: next cycle div=0, h=0, v=0, and every pipeline stage is loaded with the inactive value. This takes priority over p_tick and is independent of en.
- Raw signals, from h and v:
  - de_raw = h<H_ACTIVE && v<V_ACTIVE
  - hs_raw = h in the sync window
  - vs_raw = v in the sync window
- Delay pipeline: SYNC_DLY stages, each advancing only on p_tick. Output polarity is applied at the pipeline output. SYNC_DLY=0 makes the outputs combinational from h and v.
- x=h, y=v (registers, not delayed).
- line_start = p_tick && h==0.
- frame_start = p_tick && h==0 && v==0.
- line_irq = line_start && v==line_match. A line_match ≥ V_TOTAL never fires.

## Timing
- Reset values: div=0, x=0, y=0, de=0, hsync=~H_POL, vsync=~V_POL, all pipeline stages inactive. Outputs are valid during reset.
- First cycle after reset release with en=1: p_tick=1, line_start=1, frame_start=1, and line_irq=1 if line_match==0.
- Strobes are combinational and one clk wide. Successive p_ticks are exactly CLK_DIV clks apart while en=1.
- An hsync/vsync/de transition appears SYNC_DLY pixel periods after the corresponding x/y value.
- Reset mid-frame: immediate asynchronous return to reset values. Resync mid-frame: return to (0,0) one clk later, with no partial sync pulse beyond that cycle.
- en deasserted mid-pixel: the remaining div phase resumes on re-enable, so no pixel is shortened.

## Test plan
- Defaults, en=1: hsync low for exactly 96 p_ticks at x=656..751; vsync low at y=490..491; de high 640×480 pixels per frame; frame_start period = 1,680,000 clk.
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=1, SYNC_DLY=2, H_POL=1:
  - x sequence 0..7 repeating;
  - hsync high when x=7,0;
  - de first high at x=2 of y=0 after reset;
  - frame period 48 clk.
- CLK_DIV=3: toggle en low for 5 clk mid-pixel → x/y/div frozen, no strobes; p_tick spacing resumes at 3 clk.
- line_match=2, small config: line_irq pulses once per frame at x=0,y=2 in the same cycle as line_start; line_match=6 gives no pulse.
- resync at x=5,y=1: next clk x=0, y=0, de=0, hsync and vsync inactive; frame_start on the next p_tick.
- rst asserted mid-sync (hsync active): outputs go to reset values immediately, without waiting for clk.
